sha_msg_window: RTL and testbench

Parametrised message-schedule word window for the SHA-2 datapath.
- Accepts the first 16 message words of a block through a valid/ready stream.
- Then expands the block to ROUNDS words by shifting in externally computed schedule words.
- Presents the current round word W[t] and the four schedule taps to the adjacent round core and sigma logic.
- Sits between the block-buffer stream and the compression round core. Replaces fixed 32-bit load-enable registers with one stalled, counted window.

---
 rtl/sha_pkg.sv | 23 ++
 rtl/sha_msg_window_ctrl.sv | 71 +++++++
 rtl/sha_msg_window.sv | 84 ++++++++
 tb/tb_sha_msg_window.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-2 message-schedule window.
// Tap indices address the 16-word window where index 0 holds W[t-1].
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int WIN_DEPTH = 16;
  localparam int TAP2      = 1;
  localparam int TAP7      = 6;
  localparam int TAP15     = 14;
  localparam int TAP16     = 15;

  localparam int SHA256_WIDTH  = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WIDTH  = 64;
  localparam int SHA512_ROUNDS = 80;

endpackage

// File: rtl/sha_msg_window_ctrl.sv
// Sequencing for the message window: loads 16 words, then issues one
// expansion step per advance until ROUNDS words have been produced.
module sha_msg_window_ctrl
  import sha_pkg::*;
#(
  parameter  int ROUNDS = 64,
  localparam int RW     = $clog2(ROUNDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_start,
  input  logic          i_in_valid,
  input  logic          i_adv,
  output logic          o_in_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_shift,
  output logic          o_sel_new,
  output logic [RW-1:0] o_cnt
);

  localparam logic [RW-1:0] LAST_LOAD  = RW'(WIN_DEPTH - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_t        r_state;
  logic [RW-1:0] r_cnt;
  logic          w_load_acc;
  logic          w_exp_acc;

  assign w_load_acc = (r_state == LOAD) && i_in_valid;
  assign w_exp_acc  = (r_state == EXPAND) && i_adv;

  assign o_in_ready = (r_state == LOAD);
  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_shift    = w_load_acc || w_exp_acc;
  assign o_sel_new  = (r_state == EXPAND);
  assign o_cnt      = r_cnt;

  // The counter holds at the last round instead of wrapping; DONE always
  // lasts exactly one cycle, so a start seen there is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          if (i_in_valid) begin
            r_cnt <= r_cnt + RW'(1);
            if (r_cnt == LAST_LOAD) r_state <= EXPAND;
          end
        end
        EXPAND: begin
          if (i_adv) begin
            if (r_cnt == LAST_ROUND) r_state <= DONE;
            else                     r_cnt   <= r_cnt + RW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sha_msg_window.sv
// Message-schedule window: 16-word shift register fed first by the block
// stream and then by the external schedule adder, with registered W[t] output.
module sha_msg_window
  import sha_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int ROUNDS = 64,
  localparam int RW     = $clog2(ROUNDS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             adv,
  input  logic [WIDTH-1:0] w_new,
  output logic [WIDTH-1:0] w_tm2,
  output logic [WIDTH-1:0] w_tm7,
  output logic [WIDTH-1:0] w_tm15,
  output logic [WIDTH-1:0] w_tm16,
  output logic [WIDTH-1:0] w_t,
  output logic [RW-1:0]    round,
  output logic             round_valid,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_win [WIN_DEPTH];
  logic [WIDTH-1:0] r_w_t_p1;
  logic [RW-1:0]    r_round_p1;
  logic             r_vld_p1;

  logic             w_shift;
  logic             w_sel_new;
  logic [RW-1:0]    w_cnt;
  logic [WIDTH-1:0] w_word;

  sha_msg_window_ctrl #(
    .ROUNDS (ROUNDS)
  ) u_ctrl (
    .CLK        (CLK),
    .RST        (RST),
    .i_start    (start),
    .i_in_valid (in_valid),
    .i_adv      (adv),
    .o_in_ready (in_ready),
    .o_busy     (busy),
    .o_done     (done),
    .o_shift    (w_shift),
    .o_sel_new  (w_sel_new),
    .o_cnt      (w_cnt)
  );

  assign w_word = w_sel_new ? w_new : in_data;

  // Stage p1: window shift and registered W[t] with its round index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WIN_DEPTH; i++) r_win[i] <= '0;
      r_w_t_p1   <= '0;
      r_round_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_shift;
      if (w_shift) begin
        r_win[0] <= w_word;
        for (int i = 1; i < WIN_DEPTH; i++) r_win[i] <= r_win[i-1];
        r_w_t_p1   <= w_word;
        r_round_p1 <= w_cnt;
      end
    end
  end

  // Taps feed the external sigma/adder that forms the next w_new.
  assign w_tm2       = r_win[TAP2];
  assign w_tm7       = r_win[TAP7];
  assign w_tm15      = r_win[TAP15];
  assign w_tm16      = r_win[TAP16];
  assign w_t         = r_w_t_p1;
  assign round       = r_round_p1;
  assign round_valid = r_vld_p1;

endmodule

// File: tb/tb_sha_msg_window.sv
// Bench for sha_msg_window: SHA-256 and SHA-512 instances, a recurrence-level
// schedule model, table checks on known words and hand-built corner sequences.
module tb_sha_msg_window;

  localparam int BUDGET = 2000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        in_valid = 1'b0, adv = 1'b0;
  logic [63:0] in_data = '0;

  logic [31:0] wn_a, tm2_a, tm7_a, tm15_a, tm16_a, wt_a;
  logic [5:0]  rnd_a;
  logic        rdy_a, rv_a, busy_a, done_a;
  logic [63:0] wn_b, tm2_b, tm7_b, tm15_b, tm16_b, wt_b;
  logic [6:0]  rnd_b;
  logic        rdy_b, rv_b, busy_b, done_b;

  int n_checks = 0, n_errors = 0;
  int sel = 0;
  int nxt_a = 0, nxt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic [63:0] msg [16];
  logic [63:0] exp_a [128], exp_b [128], got_a [128], got_b [128];

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  assign wn_a = s1_32(tm2_a) + tm7_a + s0_32(tm15_a) + tm16_a;
  assign wn_b = s1_64(tm2_b) + tm7_b + s0_64(tm15_b) + tm16_b;

  sha_msg_window #(.WIDTH(32), .ROUNDS(64)) u_a (
    .CLK(CLK), .RST(RST), .start(start_a), .in_valid(in_valid), .in_data(in_data[31:0]),
    .in_ready(rdy_a), .adv(adv), .w_new(wn_a), .w_tm2(tm2_a), .w_tm7(tm7_a),
    .w_tm15(tm15_a), .w_tm16(tm16_a), .w_t(wt_a), .round(rnd_a),
    .round_valid(rv_a), .busy(busy_a), .done(done_a));

  sha_msg_window #(.WIDTH(64), .ROUNDS(80)) u_b (
    .CLK(CLK), .RST(RST), .start(start_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .adv(adv), .w_new(wn_b), .w_tm2(tm2_b), .w_tm7(tm7_b),
    .w_tm15(tm15_b), .w_tm16(tm16_b), .w_t(wt_b), .round(rnd_b),
    .round_valid(rv_b), .busy(busy_b), .done(done_b));

  // View of whichever instance the current test drives.
  logic [63:0] c_wt, c_t2, c_t7, c_t15, c_t16;
  logic [7:0]  c_rnd;
  logic        c_rv, c_rdy, c_busy, c_done;
  assign c_wt   = (sel != 0) ? wt_b   : 64'(wt_a);
  assign c_t2   = (sel != 0) ? tm2_b  : 64'(tm2_a);
  assign c_t7   = (sel != 0) ? tm7_b  : 64'(tm7_a);
  assign c_t15  = (sel != 0) ? tm15_b : 64'(tm15_a);
  assign c_t16  = (sel != 0) ? tm16_b : 64'(tm16_a);
  assign c_rnd  = (sel != 0) ? 8'(rnd_b) : 8'(rnd_a);
  assign c_rv   = (sel != 0) ? rv_b   : rv_a;
  assign c_rdy  = (sel != 0) ? rdy_b  : rdy_a;
  assign c_busy = (sel != 0) ? busy_b : busy_a;
  assign c_done = (sel != 0) ? done_b : done_a;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference schedule straight from the SHA-2 recurrence.
  function automatic void compute_exp(input int s);
    logic [63:0] ex [128];
    for (int t = 0; t < 128; t++) ex[t] = '0;
    for (int t = 0; t < 16; t++) ex[t] = (s != 0) ? msg[t] : {32'h0, msg[t][31:0]};
    for (int t = 16; t < ((s != 0) ? 80 : 64); t++) begin
      if (s != 0) ex[t] = s1_64(ex[t-2]) + ex[t-7] + s0_64(ex[t-15]) + ex[t-16];
      else ex[t] = {32'h0, s1_32(ex[t-2][31:0]) + ex[t-7][31:0] + s0_32(ex[t-15][31:0]) + ex[t-16][31:0]};
    end
    if (s != 0) exp_b = ex; else exp_a = ex;
  endfunction

  // Every issued word is checked against the model and for contiguous rounds.
  always @(negedge CLK) begin
    if (!RST) begin
      if (rv_a) begin
        chk("a_round_seq", 64'(rnd_a), 64'(nxt_a));
        chk("a_w_t", 64'(wt_a), exp_a[rnd_a]);
        got_a[rnd_a] = 64'(wt_a);
        nxt_a++;
      end
      if (done_a) begin
        chk("a_done_at_last", 64'({rv_a, rnd_a}), 64'({1'b1, 6'd63}));
        done_cnt_a++;
      end
      if (rv_b) begin
        chk("b_round_seq", 64'(rnd_b), 64'(nxt_b));
        chk("b_w_t", wt_b, exp_b[rnd_b]);
        got_b[rnd_b] = wt_b;
        nxt_b++;
      end
      if (done_b) begin
        chk("b_done_at_last", 64'({rv_b, rnd_b}), 64'({1'b1, 7'd79}));
        done_cnt_b++;
      end
    end
  end

  task automatic set_start(input int s, input logic v);
    if (s != 0) start_b = v; else start_a = v;
  endtask

  task automatic run_block(input int s, input int vmode, input int amode,
                           input int stall_at, input int sb_at);
    int rounds, k, cyc, d0;
    logic acc, sb_pending;
    logic [63:0] s_wt, s_t2, s_t7, s_t15, s_t16;
    rounds = (s != 0) ? 80 : 64;
    k = 0; cyc = 0; sb_pending = 1'b0;
    sel = s;
    compute_exp(s);
    if (s != 0) begin nxt_b = 0; d0 = done_cnt_b; end
    else        begin nxt_a = 0; d0 = done_cnt_a; end
    #1;
    chk("idle_before_start", 64'({c_busy, c_rdy}), 64'd0);
    set_start(s, 1'b1);
    @(posedge CLK); #1;
    set_start(s, 1'b0);
    while (k < 16 && cyc < BUDGET) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = msg[k];
      adv = 1'($urandom_range(0, 1));
      chk("in_ready_load", 64'(c_rdy), 64'd1);
      @(posedge CLK); acc = in_valid; #1; cyc++;
      if (acc) begin
        chk("load_accept", 64'({c_rv, c_rnd}), 64'({1'b1, 8'(k)}));
        k++;
      end else begin
        chk("load_hold", 64'(c_rv), 64'd0);
      end
    end
    in_valid = 1'b0;
    adv = 1'b1;
    while (!c_done && cyc < BUDGET) begin
      @(posedge CLK); #1; cyc++;
      set_start(s, 1'b0);
      if (sb_pending) begin
        chk("start_while_busy", 64'({c_busy, c_rdy}), 64'({1'b1, 1'b0}));
        sb_pending = 1'b0;
      end
      if (c_done) break;
      if (stall_at >= 0 && c_rv && c_rnd == 8'(stall_at)) begin
        adv = 1'b0;
        s_wt = c_wt; s_t2 = c_t2; s_t7 = c_t7; s_t15 = c_t15; s_t16 = c_t16;
        for (int j = 0; j < 3; j++) begin
          @(posedge CLK); #1; cyc++;
          chk("stall_w_t", c_wt, s_wt);
          chk("stall_taps", {c_t2 ^ s_t2} | {c_t7 ^ s_t7} | {c_t15 ^ s_t15} | {c_t16 ^ s_t16}, 64'd0);
          chk("stall_no_rv", 64'({c_rv, c_rnd}), 64'({1'b0, 8'(stall_at)}));
        end
        adv = 1'b1;
        @(posedge CLK); #1; cyc++;
        chk("stall_resume", 64'({c_rv, c_rnd}), 64'({1'b1, 8'(stall_at + 1)}));
      end
      if (sb_at >= 0 && c_rv && c_rnd == 8'(sb_at)) begin
        set_start(s, 1'b1);
        sb_pending = 1'b1;
      end
      adv = (amode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!c_done) begin
      chk("timeout_waiting_done", 64'd0, 64'd1);
      adv = 1'b0;
    end else begin
      if (sb_at >= 0) set_start(s, 1'b1);
      adv = 1'b0;
      @(negedge CLK); #1;
      chk("words_issued", 64'((s != 0) ? nxt_b : nxt_a), 64'(rounds));
      chk("done_count", 64'((s != 0) ? done_cnt_b : done_cnt_a), 64'(d0 + 1));
      @(posedge CLK); #1;
      set_start(s, 1'b0);
      chk("idle_after_done", 64'({c_busy, c_rdy, c_done}), 64'd0);
      @(posedge CLK); #1;
      chk("start_in_done_ignored", 64'(c_busy), 64'd0);
    end
  endtask

  typedef struct {
    int          s;
    int          rnd;
    logic [63:0] val;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int d0;
    tbl[0] = '{0, 0,  64'h61626380};
    tbl[1] = '{0, 1,  64'h0};
    tbl[2] = '{0, 14, 64'h0};
    tbl[3] = '{0, 15, 64'h18};
    tbl[4] = '{0, 16, 64'h61626380};
    tbl[5] = '{0, 17, 64'h000F0000};
    tbl[6] = '{1, 0,  64'hFFFFFFFF00000000};
    tbl[7] = '{1, 1,  64'h00000000FFFFFFFF};
    tbl[8] = '{1, 14, 64'hFFFFFFFF00000000};

    // Reset state.
    #1;
    chk("rst_a_wt_taps", 64'(wt_a | tm2_a | tm7_a | tm15_a | tm16_a), 64'd0);
    chk("rst_a_ctl", 64'({rv_a, busy_a, rdy_a, done_a, rnd_a}), 64'd0);
    chk("rst_b_wt_taps", wt_b | tm2_b | tm7_b | tm15_b | tm16_b, 64'd0);
    chk("rst_b_ctl", 64'({rv_b, busy_b, rdy_b, done_b, rnd_b}), 64'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset in the middle of LOAD after five words.
    sel = 0;
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    compute_exp(0);
    nxt_a = 0; d0 = done_cnt_a;
    start_a = 1'b1;
    @(posedge CLK); #1 start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = msg[i];
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_round", 64'({rv_a, rnd_a}), 64'({1'b1, 6'd4}));
    @(negedge CLK); #1 RST = 1'b1;
    #1;
    chk("midrst_wt_taps", 64'(wt_a | tm2_a | tm7_a | tm15_a | tm16_a), 64'd0);
    chk("midrst_ctl", 64'({rv_a, busy_a, rdy_a, done_a, rnd_a}), 64'd0);
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_idle", 64'({busy_a, rdy_a}), 64'd0);
    chk("midrst_no_done", 64'(done_cnt_a), 64'(d0));

    // SHA-256 "abc" block, 16 fresh words after the aborted block.
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = 64'h61626380;
    msg[15] = 64'h18;
    run_block(0, 0, 0, -1, -1);

    // SHA-512 with upper-half patterns.
    for (int i = 0; i < 16; i++) msg[i] = (i % 2 == 0) ? 64'hFFFFFFFF00000000 : 64'h00000000FFFFFFFF;
    run_block(1, 0, 0, -1, -1);

    for (int i = 0; i < 9; i++)
      chk($sformatf("table_%0d_r%0d", tbl[i].s, tbl[i].rnd),
          (tbl[i].s != 0) ? got_b[tbl[i].rnd] : got_a[tbl[i].rnd], tbl[i].val);

    // Load backpressure, expand stall at 20, start while busy at 30 and in DONE.
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    run_block(0, 1, 0, 20, 30);

    // Randomised blocks on both widths.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
      run_block(n % 2, 2, 1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
